// File: rtl/elevator_pkg.sv
// Shared elevator definitions: timer FSM state encodings and default 32 Hz tick constants.
package elevator_pkg;

    localparam int CNT_W = 7;

    localparam int RUN_TICKS_32HZ  = 64;
    localparam int DOOR_TICKS_32HZ = 96;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_RUN_DONE  = 3'd2,
        ST_DOOR      = 3'd3,
        ST_DOOR_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/run_door_timer_if.sv
// Controller <-> run/door timer bundle: requests and buttons in, handshake pulses and status out.
interface run_door_timer_if;
    import elevator_pkg::*;

    logic             switch;
    logic             opendoor;
    logic             mv2nxt;
    logic             open_btn;
    logic             close_btn;
    logic             endRun;
    logic             endOpen;
    logic [CNT_W-1:0] DoorCount;
    logic             moving;
    logic             door_busy;

    modport master (
        output switch, opendoor, mv2nxt, open_btn, close_btn,
        input  endRun, endOpen, DoorCount, moving, door_busy
    );

    modport slave (
        input  switch, opendoor, mv2nxt, open_btn, close_btn,
        output endRun, endOpen, DoorCount, moving, door_busy
    );
endinterface

// File: rtl/run_door_timer_tick_counter.sv
// 7-bit up counter with synchronous clear (dominant), enable and terminal-count flag at LIMIT-1.
module tick_counter
    import elevator_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en)
            count <= count + 7'd1;
    end

    assign tc = (count == 7'(LIMIT - 1));

endmodule

// File: rtl/run_door_timer.sv
// Elevator run/door timing responder: times a floor run and a door cycle, answering with endRun/endOpen pulses.
module run_door_timer
    import elevator_pkg::*;
#(
    parameter int RUN_TICKS  = RUN_TICKS_32HZ,
    parameter int DOOR_TICKS = DOOR_TICKS_32HZ,
    parameter int MIN_OPEN   = 32,
    parameter int EXT_MAX    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    run_door_timer_if.slave bus
);

    state_t           state, nxt;
    logic [CNT_W-1:0] run_cnt, door_cnt, ext_cnt;
    logic             run_tc, door_tc;
    logic             run_clr, run_en, door_clr, door_en, ext_clr, ext_inc;
    logic             end_run_nxt, end_open_nxt;
    logic             end_run_q, end_open_q, moving_q, door_busy_q;
    logic             rst_act;

    // switch low behaves exactly like reset
    assign rst_act = !rst_n || !bus.switch;

    tick_counter #(.LIMIT(RUN_TICKS)) u_run (
        .clk   (clk),
        .clr   (rst_act || run_clr),
        .en    (run_en),
        .count (run_cnt),
        .tc    (run_tc)
    );

    tick_counter #(.LIMIT(DOOR_TICKS)) u_door (
        .clk   (clk),
        .clr   (rst_act || door_clr),
        .en    (door_en),
        .count (door_cnt),
        .tc    (door_tc)
    );

    always_ff @(posedge clk) begin
        if (rst_act) begin
            state       <= ST_IDLE;
            ext_cnt     <= '0;
            end_run_q   <= 1'b0;
            end_open_q  <= 1'b0;
            moving_q    <= 1'b0;
            door_busy_q <= 1'b0;
        end else begin
            state       <= nxt;
            if (ext_clr)
                ext_cnt <= '0;
            else if (ext_inc)
                ext_cnt <= ext_cnt + 7'd1;
            end_run_q   <= end_run_nxt;
            end_open_q  <= end_open_nxt;
            moving_q    <= (nxt == ST_RUN);
            door_busy_q <= (nxt == ST_DOOR);
        end
    end

    always_comb begin
        nxt          = state;
        run_clr      = 1'b0;
        run_en       = 1'b0;
        door_clr     = 1'b0;
        door_en      = 1'b0;
        ext_clr      = 1'b0;
        ext_inc      = 1'b0;
        end_run_nxt  = 1'b0;
        end_open_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.opendoor) begin
                    nxt      = ST_DOOR;
                    door_clr = 1'b1;
                    ext_clr  = 1'b1;
                end else if (bus.mv2nxt) begin
                    nxt     = ST_RUN;
                    run_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.mv2nxt) begin
                    nxt     = ST_IDLE;
                    run_clr = 1'b1;
                end else if (run_tc) begin
                    nxt         = ST_RUN_DONE;
                    run_clr     = 1'b1;
                    end_run_nxt = 1'b1;
                end else begin
                    run_en = 1'b1;
                end
            end
            ST_RUN_DONE: begin
                if (!bus.mv2nxt)
                    nxt = ST_IDLE;
            end
            ST_DOOR: begin
                // abort, then open-button extension, then early close, then natural expiry
                if (!bus.opendoor) begin
                    nxt      = ST_IDLE;
                    door_clr = 1'b1;
                end else if (bus.open_btn && (ext_cnt < 7'(EXT_MAX))) begin
                    door_clr = 1'b1;
                    ext_inc  = 1'b1;
                end else if (bus.close_btn && !bus.open_btn && (door_cnt >= 7'(MIN_OPEN))) begin
                    nxt          = ST_DOOR_DONE;
                    end_open_nxt = 1'b1;
                end else if (door_tc) begin
                    nxt          = ST_DOOR_DONE;
                    end_open_nxt = 1'b1;
                end else begin
                    door_en = 1'b1;
                end
            end
            ST_DOOR_DONE: begin
                // DoorCount held through the pulse cycle, zeroed on the following edge
                door_clr = 1'b1;
                if (!bus.opendoor)
                    nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    assign bus.endRun    = end_run_q;
    assign bus.endOpen   = end_open_q;
    assign bus.DoorCount = door_cnt;
    assign bus.moving    = moving_q;
    assign bus.door_busy = door_busy_q;

endmodule

// File: tb/tb_run_door_timer.sv
// Directed bench for run_door_timer with default parameters (64/96/32/3).
module tb_run_door_timer;
    import elevator_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    run_door_timer_if bus_if ();

    run_door_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"},   int'(dut.state), int'(ST_IDLE));
        chk({tag, "_moving"},  int'(bus_if.moving), 0);
        chk({tag, "_busy"},    int'(bus_if.door_busy), 0);
        chk({tag, "_dc"},      int'(bus_if.DoorCount), 0);
        chk({tag, "_endrun"},  int'(bus_if.endRun), 0);
        chk({tag, "_endopen"}, int'(bus_if.endOpen), 0);
    endtask

    initial begin
        int pulses;
        checks            = 0;
        errors            = 0;
        rst_n             = 1'b0;
        bus_if.switch     = 1'b1;
        bus_if.opendoor   = 1'b0;
        bus_if.mv2nxt     = 1'b0;
        bus_if.open_btn   = 1'b0;
        bus_if.close_btn  = 1'b0;
        step(2);
        chk_idle("reset");
        chk("reset_runcnt", int'(dut.run_cnt), 0);
        chk("reset_ext", int'(dut.ext_cnt), 0);
        rst_n = 1'b1;
        step(1);

        // full run
        bus_if.mv2nxt = 1'b1;
        step(1);
        chk("run_moving", int'(bus_if.moving), 1);
        step(63);
        chk("run_early", int'(bus_if.endRun), 0);
        step(1);
        chk("run_pulse", int'(bus_if.endRun), 1);
        chk("run_pulse_moving", int'(bus_if.moving), 0);
        chk("run_pulse_open", int'(bus_if.endOpen), 0);
        step(1);
        chk("run_pulse_width", int'(bus_if.endRun), 0);
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (bus_if.endRun) pulses++;
        end
        chk("run_no_repeat", pulses, 0);
        chk("run_done_state", int'(dut.state), int'(ST_RUN_DONE));
        bus_if.mv2nxt = 1'b0;
        step(1);
        chk_idle("run_release");

        // plain door cycle
        bus_if.opendoor = 1'b1;
        step(1);
        chk("door_busy", int'(bus_if.door_busy), 1);
        chk("door_dc0", int'(bus_if.DoorCount), 0);
        step(95);
        chk("door_dc95", int'(bus_if.DoorCount), 95);
        chk("door_early", int'(bus_if.endOpen), 0);
        step(1);
        chk("door_pulse", int'(bus_if.endOpen), 1);
        chk("door_pulse_dc", int'(bus_if.DoorCount), 95);
        chk("door_pulse_busy", int'(bus_if.door_busy), 0);
        step(1);
        chk("door_pulse_width", int'(bus_if.endOpen), 0);
        chk("door_done_dc", int'(bus_if.DoorCount), 0);
        bus_if.opendoor = 1'b0;
        step(1);
        chk_idle("door_release");

        // open-button extensions: three honoured, fourth ignored
        bus_if.opendoor = 1'b1;
        step(1);
        for (int e = 0; e < 3; e++) begin
            step(50);
            chk("ext_dc50", int'(bus_if.DoorCount), 50);
            bus_if.open_btn = 1'b1;
            step(1);
            bus_if.open_btn = 1'b0;
            chk("ext_reset", int'(bus_if.DoorCount), 0);
        end
        chk("ext_cnt3", int'(dut.ext_cnt), 3);
        step(50);
        bus_if.open_btn = 1'b1;
        step(1);
        bus_if.open_btn = 1'b0;
        chk("ext_ignored", int'(bus_if.DoorCount), 51);
        step(44);
        chk("ext_dc95", int'(bus_if.DoorCount), 95);
        chk("ext_early", int'(bus_if.endOpen), 0);
        step(1);
        chk("ext_pulse", int'(bus_if.endOpen), 1);
        step(1);
        bus_if.opendoor = 1'b0;
        step(1);
        chk_idle("ext_release");

        // close button below and above MIN_OPEN
        bus_if.opendoor = 1'b1;
        step(21);
        chk("close_dc20", int'(bus_if.DoorCount), 20);
        bus_if.close_btn = 1'b1;
        step(1);
        bus_if.close_btn = 1'b0;
        chk("close_low_ignored", int'(bus_if.endOpen), 0);
        chk("close_low_dc", int'(bus_if.DoorCount), 21);
        step(19);
        chk("close_dc40", int'(bus_if.DoorCount), 40);
        bus_if.close_btn = 1'b1;
        step(1);
        bus_if.close_btn = 1'b0;
        chk("close_pulse", int'(bus_if.endOpen), 1);
        chk("close_pulse_dc", int'(bus_if.DoorCount), 40);
        step(1);
        chk("close_pulse_width", int'(bus_if.endOpen), 0);
        bus_if.opendoor = 1'b0;
        step(1);
        chk_idle("close_release");

        // open beats close
        bus_if.opendoor = 1'b1;
        step(41);
        chk("both_dc40", int'(bus_if.DoorCount), 40);
        bus_if.open_btn  = 1'b1;
        bus_if.close_btn = 1'b1;
        step(1);
        bus_if.open_btn  = 1'b0;
        bus_if.close_btn = 1'b0;
        chk("both_dc0", int'(bus_if.DoorCount), 0);
        chk("both_no_pulse", int'(bus_if.endOpen), 0);
        chk("both_busy", int'(bus_if.door_busy), 1);
        bus_if.opendoor = 1'b0;
        step(1);
        chk_idle("both_abort");

        // simultaneous requests: door wins
        bus_if.opendoor = 1'b1;
        bus_if.mv2nxt   = 1'b1;
        step(1);
        chk("prio_busy", int'(bus_if.door_busy), 1);
        chk("prio_moving", int'(bus_if.moving), 0);
        bus_if.opendoor = 1'b0;
        bus_if.mv2nxt   = 1'b0;
        step(1);
        chk_idle("prio_abort");

        // run aborted at run_cnt=30
        bus_if.mv2nxt = 1'b1;
        step(31);
        chk("abort_runcnt30", int'(dut.run_cnt), 30);
        chk("abort_moving", int'(bus_if.moving), 1);
        bus_if.mv2nxt = 1'b0;
        step(1);
        chk_idle("run_abort");
        chk("abort_runcnt0", int'(dut.run_cnt), 0);

        // switch off mid door cycle, then restart
        bus_if.opendoor = 1'b1;
        step(61);
        chk("sw_dc60", int'(bus_if.DoorCount), 60);
        bus_if.switch = 1'b0;
        step(1);
        chk_idle("switch_off");
        bus_if.switch = 1'b1;
        step(1);
        chk("sw_restart_busy", int'(bus_if.door_busy), 1);
        chk("sw_restart_dc0", int'(bus_if.DoorCount), 0);
        step(5);
        chk("sw_restart_dc5", int'(bus_if.DoorCount), 5);
        rst_n = 1'b0;
        step(1);
        chk_idle("rst_mid");
        rst_n           = 1'b1;
        bus_if.opendoor = 1'b0;
        step(1);
        chk_idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
